// File: rtl/afifo_rd_stream.sv
// Read-side drain stage for an asynchronous FIFO: pops show-ahead words into a
// two-entry registered buffer and presents them as a packet-tagged valid/ready stream.
module afifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rd_en,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam logic [7:0]           LAST_IDX = 8'(PKT_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [7:0]            r_pkt_idx;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic w_push;
  logic w_pop;

  // Pop decision uses only the registered occupancy, so m_ready never reaches rinc.
  assign rinc     = rd_en & ~rempty & (r_occ != 2'd2);
  assign w_push   = rinc;
  assign w_pop    = m_valid & m_ready;

  assign m_valid  = (r_occ != 2'd0);
  assign m_data   = r_head;
  assign m_last   = m_valid & (r_pkt_idx == LAST_IDX);
  assign word_cnt = r_cnt;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_occ     <= 2'd0;
      r_head    <= '0;
      r_tail    <= '0;
      r_pkt_idx <= 8'd0;
      r_cnt     <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_head <= rdata;
          else               r_tail <= rdata;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        // Push with pop only happens at occupancy 1: the new word replaces the head.
        2'b11:   r_head <= rdata;
        default: ;
      endcase

      if (w_pop) begin
        r_cnt     <= r_cnt + CNT_ONE;
        r_pkt_idx <= (r_pkt_idx == LAST_IDX) ? 8'd0 : r_pkt_idx + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Scoreboard bench for afifo_rd_stream: a show-ahead FIFO model feeds the DUT and a
// negedge monitor checks every delivered word against the expected-word queue.
module tb_afifo_rd_stream;

  localparam int DW   = 8;
  localparam int PLEN = 4;
  localparam int CW   = 4;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic [CW-1:0] c;
  } exp_t;

  logic          rclk = 1'b0;
  logic          rrst_n, rd_en, rempty, rinc, m_valid, m_last, m_ready;
  logic [DW-1:0] rdata, m_data;
  logic [CW-1:0] word_cnt;

  afifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(PLEN), .CNT_WIDTH(CW)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rd_en(rd_en), .rempty(rempty), .rdata(rdata),
    .rinc(rinc), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .word_cnt(word_cnt)
  );

  always #5 rclk = ~rclk;

  logic [DW-1:0] fifo_q[$];
  exp_t          exp_q[$];
  logic [DW-1:0] last_q[$];
  int            total = 0;
  int            bad = 0;
  int            rinc_cnt = 0;
  int            exp_idx = 0;
  int            exp_cnt = 0;
  bit            pop_pend = 1'b0;
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic refresh();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? '0 : fifo_q[0];
  endtask

  task automatic load(input logic [DW-1:0] d);
    exp_t e;
    e.d = d;
    e.l = (exp_idx == PLEN - 1);
    e.c = CW'(exp_cnt);
    exp_q.push_back(e);
    fifo_q.push_back(d);
    exp_idx = (exp_idx + 1) % PLEN;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    refresh();
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
    if (pop_pend && fifo_q.size() != 0) void'(fifo_q.pop_front());
    pop_pend = 1'b0;
    refresh();
    #1;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && !m_valid && rempty) && n < budget) begin
      tick();
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  // Monitor: inputs only change just after posedge, so negedge sees what the next edge samples.
  always @(negedge rclk) begin
    if (!rrst_n) begin
      prev_hold = 1'b0;
    end else begin
      chk("rinc_vs_empty", int'(rinc & rempty), 0);
      if (rinc) rinc_cnt++;
      pop_pend = rinc;
      if (prev_hold) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_data", int'(m_data), int'(prev_data));
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", int'(m_data), -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_data", int'(m_data), int'(e.d));
          chk("sb_last", int'(m_last), int'(e.l));
          chk("sb_cnt", int'(word_cnt), int'(e.c));
          if (m_last) last_q.push_back(m_data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rrst_n = 1'b0; rd_en = 1'b0; m_ready = 1'b0;
    refresh();
    repeat (2) @(posedge rclk);
    #1;
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_data", int'(m_data), 0);
    chk("rst_last", int'(m_last), 0);
    chk("rst_rinc", int'(rinc), 0);
    chk("rst_cnt", int'(word_cnt), 0);
    rrst_n = 1'b1;
    tick();

    // Basic drain of three words at full rate
    rinc_cnt = 0; rd_en = 1'b1; m_ready = 1'b1;
    load(8'h11); load(8'h22); load(8'h33);
    #1;
    chk("t1_rinc0", int'(rinc), 1);
    tick(); chk("t1_rinc1", int'(rinc), 1); chk("t1_v1", int'(m_valid), 1); chk("t1_d1", int'(m_data), 'h11);
    tick(); chk("t1_rinc2", int'(rinc), 1); chk("t1_d2", int'(m_data), 'h22);
    tick(); chk("t1_rinc3", int'(rinc), 0); chk("t1_d3", int'(m_data), 'h33);
    tick(); chk("t1_vend", int'(m_valid), 0); chk("t1_cnt", int'(word_cnt), 3);
    chk("t1_rinc_cnt", rinc_cnt, 3);

    // Backpressure fills the buffer, then releases
    m_ready = 1'b0; rinc_cnt = 0;
    load(8'hA1); load(8'hA2); load(8'hA3); load(8'hA4); load(8'hA5);
    repeat (4) tick();
    chk("t2_rinc_full", int'(rinc), 0);
    chk("t2_valid", int'(m_valid), 1);
    chk("t2_head", int'(m_data), 'hA1);
    chk("t2_pops_held", rinc_cnt, 2);
    m_ready = 1'b1;
    wait_drain("t2_drain", 30);
    chk("t2_pops_all", rinc_cnt, 5);
    chk("t2_cnt", int'(word_cnt), 8);

    // Packet tagging over nine words, plus counter wrap at 16
    last_q.delete();
    for (int i = 0; i < 9; i++) load(DW'(i));
    wait_drain("t3_drain", 40);
    chk("t3_nlast", last_q.size(), 2);
    if (last_q.size() == 2) begin
      chk("t3_last0", int'(last_q[0]), 'h03);
      chk("t3_last1", int'(last_q[1]), 'h07);
    end
    chk("t3_wrap_cnt", int'(word_cnt), 1);

    // rd_en drop with a full buffer
    m_ready = 1'b0; rinc_cnt = 0;
    load(8'hB1); load(8'hB2); load(8'hB3); load(8'hB4);
    tick(); tick();
    chk("t4_full_rinc", int'(rinc), 0);
    rd_en = 1'b0; m_ready = 1'b1;
    tick(); chk("t4_rinc_off", int'(rinc), 0); chk("t4_d", int'(m_data), 'hB2);
    tick(); chk("t4_vend", int'(m_valid), 0);
    tick(); chk("t4_idle_rinc", int'(rinc), 0);
    chk("t4_pops", rinc_cnt, 2);
    rd_en = 1'b1;
    #1;
    chk("t4_rinc_on", int'(rinc), 1);
    wait_drain("t4_drain", 20);
    chk("t4_cnt", int'(word_cnt), 5);

    // Async reset mid-stream with two words buffered
    load(8'hC1);
    wait_drain("t5_pre", 20);
    m_ready = 1'b0;
    load(8'hC2); load(8'hC3);
    repeat (3) tick();
    chk("t5_valid", int'(m_valid), 1);
    chk("t5_head", int'(m_data), 'hC2);
    chk("t5_cnt", int'(word_cnt), 6);
    #2;
    rrst_n = 1'b0;
    #1;
    chk("t5_rst_valid", int'(m_valid), 0);
    chk("t5_rst_rinc", int'(rinc), 0);
    chk("t5_rst_cnt", int'(word_cnt), 0);
    chk("t5_rst_data", int'(m_data), 0);
    exp_q.delete(); fifo_q.delete();
    exp_idx = 0; exp_cnt = 0;
    refresh();
    tick(); tick();
    rrst_n = 1'b1; m_ready = 1'b1; rd_en = 1'b1;
    load(8'hD0); load(8'hD1); load(8'hD2); load(8'hD3);
    wait_drain("t5_drain", 20);
    chk("t5_post_cnt", int'(word_cnt), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
